param_loader: RTL and testbench
===============================

PARAM_LOADER -- requirements
Module: param_loader

Interface
REQ-001 Parameter NUM_BYTES, default 55, SHALL set the bytes per parameter frame (range 2..64).
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, SHALL set the maximum clk cycles allowed between bytes of one frame (16-bit range).
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 byte_valid  input  1  SHALL be a one-cycle strobe marking byte_data valid (from the UART receiver).
REQ-006 byte_data  input  8  SHALL be the received byte.
REQ-007 frame_start  input  1  SHALL be a one-cycle strobe from video timing marking the vertical-blank start.
REQ-008 rd_addr  input  6  SHALL select the active-bank byte read by the renderer.
REQ-009 rd_data  output  8  SHALL return active[rd_addr] combinationally, or 0 when rd_addr >= NUM_BYTES.
REQ-010 byte_idx  output  6  SHALL show the shadow-bank index the next accepted byte will be written to.
REQ-011 load_busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-012 swap_done  output  1  SHALL pulse for one cycle after each shadow-to-active commit.
REQ-013 err_timeout  output  1  SHALL pulse for one cycle when a partial frame is aborted.
REQ-014 err_overrun  output  1  SHALL pulse for one cycle when a byte is dropped in PENDING.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD and PENDING.
REQ-016 IDLE + byte_valid: write shadow[0], set byte_idx=1, go to LOAD.
REQ-017 LOAD + byte_valid: write shadow[byte_idx]; if byte_idx==NUM_BYTES-1, set byte_idx=0 and go to PENDING; otherwise increment byte_idx.
REQ-018 The gap counter SHALL clear on every accepted byte and increment on every other LOAD cycle.
REQ-019 When the gap counter reaches TIMEOUT_CYCLES-1 in LOAD, the block SHALL pulse err_timeout the next cycle, set byte_idx=0 and go to IDLE; shadow contents SHALL be retained and SHALL NOT be committed.
REQ-020 PENDING + frame_start: copy all NUM_BYTES shadow bytes into the active bank in one cycle, pulse swap_done the following cycle, go to IDLE.
REQ-021 PENDING + byte_valid without frame_start: the byte SHALL be dropped, err_overrun SHALL pulse the next cycle, and the state SHALL remain PENDING.
REQ-022 PENDING + byte_valid + frame_start in the same cycle: the commit SHALL use pre-edge shadow values, the byte SHALL be written to shadow[0], byte_idx SHALL become 1, and the state SHALL go to LOAD.
REQ-023 LOAD + final byte + frame_start in the same cycle: the byte SHALL be written and the state SHALL go to PENDING; the commit SHALL wait for the next frame_start.
REQ-024 frame_start in IDLE or LOAD SHALL have no effect.
REQ-025 The active bank SHALL change only on a commit, so rd_data is stable for a whole frame.

Reset
REQ-026 On rst_n low, the following SHALL hold asynchronously: state=IDLE; byte_idx=0; gap counter=0; all shadow and active bytes=0; swap_done, err_timeout and err_overrun all 0.
REQ-027 Reset asserted mid-LOAD or in PENDING SHALL discard the partial or pending frame with no commit.
REQ-028 On the first edge after rst_n rises, the block SHALL accept byte_valid normally.

Structure
REQ-029 Package gpu_param_pkg SHALL hold the NUM_BYTES default, the TIMEOUT_CYCLES default and the FSM state enum.
REQ-030 A single sub-module, param_bank, SHALL hold the shadow and active register arrays, the write port, the commit strobe and the read mux.

Verification
REQ-031 Send 55 bytes 0x00..0x36 with 100-cycle gaps, then frame_start: swap_done pulses once; rd_addr=10 returns 0x0A; rd_addr=60 returns 0x00.
REQ-032 Send 20 bytes, then idle for TIMEOUT_CYCLES: err_timeout pulses once, byte_idx=0, and rd_data is unchanged (all 0).
REQ-033 Send a full frame, then one extra byte 0xFF before frame_start: err_overrun pulses; after frame_start, active[0] still holds the frame's first byte.
REQ-034 In PENDING, assert byte_valid (0xAA) and frame_start in the same cycle: the commit uses the old frame, the state goes to LOAD, byte_idx=1, and the next commit holds active[0]=0xAA.
REQ-035 Assert rst_n low after 30 bytes, then send a fresh 55-byte frame and frame_start: the active bank matches only the fresh frame.

Source files
------------

// File: rtl/gpu_param_pkg.sv
// Shared defaults and FSM state encoding for the parameter loader.
package gpu_param_pkg;

  localparam int unsigned NumBytesDefault      = 55;
  localparam int unsigned TimeoutCyclesDefault = 65535;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPending
  } state_e;

endpackage

// File: rtl/param_bank.sv
// Double-buffered parameter storage: shadow bank written byte-wise, active bank
// updated wholesale on commit and read combinationally by the renderer.
module param_bank
  import gpu_param_pkg::*;
#(
  parameter int unsigned NumBytes = NumBytesDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  logic [5:0] i_wr_addr,
  input  logic [7:0] i_wr_data,
  input  logic       i_commit,
  input  logic [5:0] i_rd_addr,
  output logic [7:0] o_rd_data
);

  localparam int unsigned AddrW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [6:0]  NumBytesW = 7'(NumBytes);

  logic [7:0] r_shadow [NumBytes];
  logic [7:0] r_active [NumBytes];

  // Commit samples pre-edge shadow, so a same-cycle write lands in the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumBytes; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (i_commit) begin
        for (int i = 0; i < NumBytes; i++) begin
          r_active[i] <= r_shadow[i];
        end
      end
      if (i_wr_en) begin
        r_shadow[i_wr_addr[AddrW-1:0]] <= i_wr_data;
      end
    end
  end

  always_comb begin
    o_rd_data = 8'h00;
    if ({1'b0, i_rd_addr} < NumBytesW) begin
      o_rd_data = r_active[i_rd_addr[AddrW-1:0]];
    end
  end

endmodule

// File: rtl/param_loader.sv
// Assembles UART bytes into a parameter frame and commits it to the active bank
// at vertical-blank start, with inter-byte timeout and overrun reporting.
module param_loader
  import gpu_param_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = NumBytesDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       frame_start,
  input  logic [5:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [5:0] byte_idx,
  output logic       load_busy,
  output logic       swap_done,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam logic [5:0]  LastIdx  = 6'(NUM_BYTES - 1);
  localparam logic [15:0] GapLimit = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state, w_state_next;
  logic [5:0]  r_idx, w_idx_next;
  logic [15:0] r_gap, w_gap_next;
  logic        r_swap_done, w_swap_done_next;
  logic        r_err_timeout, w_err_timeout_next;
  logic        r_err_overrun, w_err_overrun_next;
  logic        w_wr_en, w_commit;
  logic [5:0]  w_wr_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_idx         <= '0;
      r_gap         <= '0;
      r_swap_done   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_idx         <= w_idx_next;
      r_gap         <= w_gap_next;
      r_swap_done   <= w_swap_done_next;
      r_err_timeout <= w_err_timeout_next;
      r_err_overrun <= w_err_overrun_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_idx_next         = r_idx;
    w_gap_next         = r_gap;
    w_swap_done_next   = 1'b0;
    w_err_timeout_next = 1'b0;
    w_err_overrun_next = 1'b0;
    w_wr_en            = 1'b0;
    w_wr_addr          = 6'd0;
    w_commit           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (byte_valid) begin
          w_wr_en      = 1'b1;
          w_idx_next   = 6'd1;
          w_gap_next   = '0;
          w_state_next = StLoad;
        end
      end
      StLoad: begin
        if (byte_valid) begin
          w_wr_en    = 1'b1;
          w_wr_addr  = r_idx;
          w_gap_next = '0;
          if (r_idx == LastIdx) begin
            w_idx_next   = 6'd0;
            w_state_next = StPending;
          end else begin
            w_idx_next = r_idx + 6'd1;
          end
        end else if (r_gap == GapLimit) begin
          w_err_timeout_next = 1'b1;
          w_idx_next         = 6'd0;
          w_gap_next         = '0;
          w_state_next       = StIdle;
        end else begin
          w_gap_next = r_gap + 16'd1;
        end
      end
      StPending: begin
        if (frame_start) begin
          w_commit         = 1'b1;
          w_swap_done_next = 1'b1;
          if (byte_valid) begin
            // Byte arriving with vblank starts the next frame immediately.
            w_wr_en      = 1'b1;
            w_idx_next   = 6'd1;
            w_gap_next   = '0;
            w_state_next = StLoad;
          end else begin
            w_state_next = StIdle;
          end
        end else if (byte_valid) begin
          w_err_overrun_next = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  param_bank #(
    .NumBytes(NUM_BYTES)
  ) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(w_wr_addr),
    .i_wr_data(byte_data),
    .i_commit (w_commit),
    .i_rd_addr(rd_addr),
    .o_rd_data(rd_data)
  );

  assign byte_idx    = r_idx;
  assign load_busy   = (r_state != StIdle);
  assign swap_done   = r_swap_done;
  assign err_timeout = r_err_timeout;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_param_loader.sv
// Directed self-checking bench for param_loader.
module tb_param_loader;

  localparam int unsigned NB = 55;
  localparam int unsigned TO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       frame_start = 1'b0;
  logic [5:0] rd_addr = 6'd0;
  logic [7:0] rd_data;
  logic [5:0] byte_idx;
  logic       load_busy, swap_done, err_timeout, err_overrun;

  int n_pass = 0;
  int n_total = 0;
  int swap_cnt = 0;
  int to_cnt = 0;
  int ov_cnt = 0;
  int snap;

  param_loader #(
    .NUM_BYTES     (NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_start(frame_start),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .byte_idx   (byte_idx),
    .load_busy  (load_busy),
    .swap_done  (swap_done),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (swap_done)   swap_cnt++;
    if (err_timeout) to_cnt++;
    if (err_overrun) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic chk_rd(input string tag, input logic [5:0] addr, input logic [7:0] exp);
    rd_addr = addr;
    #1;
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_busy", 32'(load_busy), 32'd0);
    chk("reset_idx", 32'(byte_idx), 32'd0);
    chk("reset_pulses", 32'({swap_done, err_timeout, err_overrun}), 32'd0);
    chk_rd("reset_rd0", 6'd0, 8'h00);

    // Full frame with 100-cycle gaps, then commit.
    for (int i = 0; i < NB; i++) begin
      send_byte(8'(i));
      if (i < NB - 1) repeat (100) @(negedge clk);
    end
    chk("f1_pending_busy", 32'(load_busy), 32'd1);
    chk("f1_pending_idx", 32'(byte_idx), 32'd0);
    chk_rd("f1_rd_before_commit", 6'd10, 8'h00);
    snap = swap_cnt;
    pulse_frame();
    chk("f1_swap_done_now", 32'(swap_done), 32'd1);
    repeat (3) @(negedge clk);
    chk("f1_swap_once", 32'(swap_cnt - snap), 32'd1);
    chk("f1_idle", 32'(load_busy), 32'd0);
    chk_rd("f1_rd10", 6'd10, 8'h0A);
    chk_rd("f1_rd54", 6'd54, 8'h36);
    chk_rd("f1_rd60", 6'd60, 8'h00);

    // Partial frame then timeout.
    do_reset();
    chk_rd("rst_cleared_active", 6'd10, 8'h00);
    for (int i = 0; i < 20; i++) send_byte(8'(8'h50 + i));
    chk("to_idx20", 32'(byte_idx), 32'd20);
    snap = to_cnt;
    repeat (TO - 1) @(negedge clk);
    chk("to_not_yet", 32'({load_busy, err_timeout}), 32'b10);
    @(negedge clk);
    chk("to_pulse", 32'(err_timeout), 32'd1);
    chk("to_idle", 32'(load_busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("to_once", 32'(to_cnt - snap), 32'd1);
    chk("to_idx0", 32'(byte_idx), 32'd0);
    chk_rd("to_rd0", 6'd0, 8'h00);
    chk_rd("to_rd5", 6'd5, 8'h00);

    // Overrun: extra byte while pending is dropped.
    for (int i = 0; i < NB; i++) send_byte(8'(8'h10 + i));
    snap = ov_cnt;
    send_byte(8'hFF);
    chk("ov_pulse_now", 32'(err_overrun), 32'd1);
    chk("ov_still_pending", 32'({load_busy, byte_idx}), 32'h40);
    pulse_frame();
    repeat (2) @(negedge clk);
    chk("ov_once", 32'(ov_cnt - snap), 32'd1);
    chk_rd("ov_rd0", 6'd0, 8'h10);
    chk_rd("ov_rd54", 6'd54, 8'h46);

    // Byte and frame_start together while pending.
    for (int i = 0; i < NB; i++) send_byte(8'(8'h80 + i));
    @(negedge clk);
    byte_valid  = 1'b1;
    byte_data   = 8'hAA;
    frame_start = 1'b1;
    @(negedge clk);
    byte_valid  = 1'b0;
    frame_start = 1'b0;
    chk("both_swap", 32'(swap_done), 32'd1);
    chk("both_load", 32'({load_busy, byte_idx}), 32'h41);
    chk_rd("both_old_rd0", 6'd0, 8'h80);
    chk_rd("both_old_rd1", 6'd1, 8'h81);
    for (int i = 1; i < NB; i++) send_byte(8'(8'hB0 + i));
    pulse_frame();
    chk_rd("both_new_rd0", 6'd0, 8'hAA);
    chk_rd("both_new_rd1", 6'd1, 8'hB1);

    // Reset mid-load discards the partial frame.
    for (int i = 0; i < 30; i++) send_byte(8'h33);
    do_reset();
    #1;
    chk("mid_rst_state", 32'({load_busy, byte_idx}), 32'h00);
    chk_rd("mid_rst_rd0", 6'd0, 8'h00);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i));
    snap = swap_cnt;
    pulse_frame();
    repeat (2) @(negedge clk);
    chk("fs_in_load_noop", 32'({swap_cnt - snap, 32'(byte_idx)}), 32'd10);
    chk_rd("fs_in_load_rd0", 6'd0, 8'h00);
    for (int i = 10; i < NB - 1; i++) send_byte(8'(8'h40 + i));
    // Final byte coincides with frame_start: no commit yet.
    @(negedge clk);
    byte_valid  = 1'b1;
    byte_data   = 8'h76;
    frame_start = 1'b1;
    @(negedge clk);
    byte_valid  = 1'b0;
    frame_start = 1'b0;
    chk("last_fs_pending", 32'({load_busy, swap_done}), 32'b10);
    chk_rd("last_fs_no_commit", 6'd0, 8'h00);
    pulse_frame();
    chk_rd("fresh_rd0", 6'd0, 8'h40);
    chk_rd("fresh_rd29", 6'd29, 8'h5D);
    chk_rd("fresh_rd54", 6'd54, 8'h76);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
